// File: rtl/shift_enc_pkg.sv
// Shared types and constants for the CPIPE1s shift-step encoder.
package shift_enc_pkg;

  localparam int CW_W  = 8;
  localparam int CNT_W = 5;

  // Fixed-field bit positions of a live step word
  localparam int BIT_EN   = 7;
  localparam int BIT_HI   = 6;
  localparam int BIT_FILL = 5;
  localparam int BIT_LO   = 1;

  // LSR1 word; every other op only differs in bit6/bit1
  localparam logic [CW_W-1:0] CW_BASE = 8'hA0;
  localparam logic [CW_W-1:0] CW_IDLE = 8'h00;

  typedef enum logic [1:0] {
    OP_LSR1 = 2'd0,
    OP_ASR1 = 2'd1,
    OP_ZLO  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/cpipe_word_enc.sv
// Combinational op -> CPIPE1s step word encoder.
module cpipe_word_enc
  import shift_enc_pkg::*;
(
  input  op_e             op_i,
  output logic [CW_W-1:0] word_o
);

  // Start from the fixed fields, then fold in the two op-dependent bits
  always_comb begin
    word_o           = CW_BASE;
    word_o[BIT_EN]   = 1'b1;
    word_o[BIT_FILL] = 1'b1;
    word_o[BIT_HI]   = op_i[1];
    word_o[BIT_LO]   = op_i[0];
  end

endmodule

// File: rtl/cpipe_shift_encoder.sv
// Issues req_count copies of a shift step word onto CPIPE1s, honouring a
// downstream stall, then pulses done for one cycle. All outputs registered.
module cpipe_shift_encoder
  import shift_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [CNT_W-1:0] req_count,
  input  logic             pipe_stall,
  output logic [CW_W-1:0]  cpipe1s,
  output logic             step_valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CW_W-1:0]  cpipe_q, cpipe_d;
  logic             step_valid_q, step_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW_W-1:0]  req_word;

  // The word is encoded from the incoming op and captured at acceptance,
  // so the latched register itself stands in for the latched op.
  cpipe_word_enc u_word_enc (
    .op_i   (op_e'(req_op)),
    .word_o (req_word)
  );

  // Next-state and next-output logic; stall only matters in ISSUE
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    cpipe_d      = cpipe_q;
    step_valid_d = step_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpipe_d      = CW_IDLE;
        step_valid_d = 1'b0;
        busy_d       = 1'b0;
        if (req_valid) begin
          remaining_d = req_count;
          busy_d      = 1'b1;
          if (req_count != '0) begin
            state_d      = ST_ISSUE;
            cpipe_d      = req_word;
            step_valid_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (!pipe_stall) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d      = ST_DONE;
            cpipe_d      = CW_IDLE;
            step_valid_d = 1'b0;
            done_d       = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        cpipe_d      = CW_IDLE;
        step_valid_d = 1'b0;
        busy_d       = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        remaining_d  = '0;
        cpipe_d      = CW_IDLE;
        step_valid_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any request or stall
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      cpipe_q      <= CW_IDLE;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      cpipe_q      <= cpipe_d;
      step_valid_q <= step_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign cpipe1s    = cpipe_q;
  assign step_valid = step_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cpipe_shift_encoder.sv
// Bench for cpipe_shift_encoder: directed cases with literal expectations
// plus randomized traffic compared every cycle against a queue model.
module tb_cpipe_shift_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [4:0] req_count;
  logic       pipe_stall;
  logic [7:0] cpipe1s;
  logic       step_valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  localparam int DONE_TOK = 256;
  logic [7:0] word_tbl [4] = '{8'hA0, 8'hA2, 8'hE0, 8'hE2};
  int mq[$];

  cpipe_shift_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_count  (req_count),
    .pipe_stall (pipe_stall),
    .cpipe1s    (cpipe1s),
    .step_valid (step_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: an accepted request becomes a queue of pending outputs, one word
  // per step followed by a done token; a stall keeps the head word in place.
  always @(posedge clk) begin
    if (rst) mq.delete();
    else if (mq.size() == 0) begin
      if (req_valid) begin
        for (int i = 0; i < int'(req_count); i++) mq.push_back(int'(word_tbl[req_op]));
        mq.push_back(DONE_TOK);
      end
    end else if (mq[0] == DONE_TOK) void'(mq.pop_front());
    else if (!pipe_stall) void'(mq.pop_front());
  end

  // Compare every cycle against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      int  head;
      bit  live;
      head = (mq.size() != 0) ? mq[0] : -1;
      live = (mq.size() != 0) && (head != DONE_TOK);
      check("m_cpipe1s",    32'(cpipe1s),    live ? 32'(head) : 32'h0);
      check("m_step_valid", 32'(step_valid), 32'(live));
      check("m_done",       32'(done),       32'(head == DONE_TOK));
      check("m_busy",       32'(busy),       32'(mq.size() != 0));
      check("m_req_ready",  32'(req_ready),  32'(mq.size() == 0));
    end
  end

  // Waits (bounded) for req_ready, presents a request, returns at the
  // negedge of cycle 1 after acceptance with req_valid still driven.
  task automatic accept(input logic [1:0] op, input logic [4:0] cnt);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_count = cnt;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_count = 5'd0; pipe_stall = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_cpipe1s", 32'(cpipe1s), 32'h00);
    check("rst_step_valid", 32'(step_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    // ASR1 x3, no stall
    accept(2'd1, 5'd3);
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("asr_word", 32'(cpipe1s), 32'hA2);
      check("asr_sv", 32'(step_valid), 32'd1);
      @(negedge clk);
    end
    check("asr_done", 32'(done), 32'd1);
    check("asr_done_sv", 32'(step_valid), 32'd0);
    @(negedge clk);
    check("asr_ready5", 32'(req_ready), 32'd1);
    check("asr_done_once", 32'(done), 32'd0);

    // PASS x2 with stall in cycle 1
    accept(2'd3, 5'd2);
    req_valid  = 1'b0;
    pipe_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      check("pass_word", 32'(cpipe1s), 32'hE2);
      @(negedge clk);
      pipe_stall = 1'b0;
    end
    check("pass_done4", 32'(done), 32'd1);
    check("pass_idle4", 32'(cpipe1s), 32'h00);

    // LSR1 x0: done straight away, no step
    accept(2'd0, 5'd0);
    req_valid = 1'b0;
    check("zero_done1", 32'(done), 32'd1);
    check("zero_sv", 32'(step_valid), 32'd0);
    check("zero_word", 32'(cpipe1s), 32'h00);
    @(negedge clk);
    check("zero_ready2", 32'(req_ready), 32'd1);

    // ZLO x31 abandoned by reset in cycle 10
    accept(2'd2, 5'd31);
    req_valid = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    check("zlo_word10", 32'(cpipe1s), 32'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("zlo_rst_word", 32'(cpipe1s), 32'h00);
    check("zlo_rst_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      check("zlo_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end

    // Held request during ISSUE with a different op
    accept(2'd0, 5'd4);
    req_op = 2'd3; req_count = 5'd1;
    for (int c = 1; c <= 4; c++) begin
      check("hold_word", 32'(cpipe1s), 32'hA0);
      @(negedge clk);
    end
    check("hold_done", 32'(done), 32'd1);
    check("hold_not_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("hold_ready6", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("hold_second", 32'(cpipe1s), 32'hE2);
    @(negedge clk);
    check("hold_second_done", 32'(done), 32'd1);

    // All four ops, one step each
    for (int op = 0; op < 4; op++) begin
      accept(2'(op), 5'd1);
      req_valid = 1'b0;
      check("op_word", 32'(cpipe1s), 32'(word_tbl[op]));
      @(negedge clk);
      check("op_word_gone", 32'(cpipe1s), 32'h00);
      check("op_done", 32'(done), 32'd1);
    end

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_op     = 2'($urandom_range(0, 3));
      req_count  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      pipe_stall = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; pipe_stall = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpipe_shift_encoder.md
CPIPE_SHIFT_ENCODER -- requirements
Module: cpipe_shift_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: a shift request is present.
REQ-004 SHALL have port req_ready, output, 1 bit: the encoder accepts a request this cycle.
REQ-005 SHALL have port req_op, input, 2 bits: operation, where 0=LSR1, 1=ASR1, 2=ZLO, 3=PASS.
REQ-006 SHALL have port req_count, input, 5 bits: number of step words to issue (0..31).
REQ-007 SHALL have port pipe_stall, input, 1 bit: downstream stall; holds the current step.
REQ-008 SHALL have port cpipe1s, output, 8 bits: registered control word driven onto the CPIPE1s bus.
REQ-009 SHALL have port step_valid, output, 1 bit: cpipe1s carries a live step this cycle.
REQ-010 SHALL have port busy, output, 1 bit: a request is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL encode step words as: bit7=1, bit5=1, bits4:2=0, bit0=0, with bit6/bit1 per op -- LSR1 0/0 (8'hA0), ASR1 0/1 (8'hA2), ZLO 1/0 (8'hE0), PASS 1/1 (8'hE2).
REQ-013 SHALL drive cpipe1s=8'h00 (bit7=0, the shift path disabled) whenever step_valid=0.
REQ-014 SHALL use a three-state FSM with states IDLE, ISSUE and DONE.
REQ-015 SHALL assert req_ready only in IDLE; the handshake completes on req_valid&req_ready.
REQ-016 SHALL, on acceptance, latch req_op, load remaining=req_count, and go to ISSUE if req_count!=0, otherwise to DONE.
REQ-017 SHALL, in ISSUE, present the latched word with step_valid=1; the first word appears in the cycle after acceptance (latency 1).
REQ-018 SHALL, in ISSUE with pipe_stall=0, decrement remaining, and go to DONE when remaining==1.
REQ-019 SHALL, in ISSUE with pipe_stall=1, hold cpipe1s, step_valid, remaining and the state unchanged.
REQ-020 SHALL, in DONE, assert done=1 for exactly one cycle with step_valid=0, then return to IDLE.
REQ-021 SHALL assert busy in ISSUE and DONE, and deassert it in IDLE.
REQ-022 SHALL, with req_count=0, issue no step and assert done 1 cycle after acceptance.
REQ-023 SHALL ignore req_valid outside IDLE; no queuing is permitted.
REQ-024 SHALL ignore pipe_stall in IDLE and in DONE.
REQ-025 SHALL drive all outputs from registers; no combinational path from inputs to cpipe1s or step_valid.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force state=IDLE, remaining=0, cpipe1s=8'h00, step_valid=0, done=0 and busy=0.
REQ-027 SHALL, when rst is asserted mid-ISSUE, abandon the request with no done pulse; req_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL give rst priority over simultaneous req_valid and pipe_stall.

Structure
REQ-029 SHALL place the following in shared package shift_enc_pkg: the op enum, the state enum, the fixed-field constants (bit positions 7, 6, 5, 1 and the 8'hA0 base) and the width constants (CW_W=8, CNT_W=5).
REQ-030 SHALL contain one combinational sub-module, cpipe_word_enc (op -> 8-bit word), instantiated once.
REQ-031 SHALL be realised as RTL of 120-400 lines in total.

Verification
REQ-032 SHALL be covered by a bench case: ASR1 with count=3, no stall -> cpipe1s=8'hA2 with step_valid=1 for cycles 1-3 after acceptance, done in cycle 4, req_ready in cycle 5.
REQ-033 SHALL be covered by a bench case: PASS with count=2 and pipe_stall=1 in cycle 1 -> 8'hE2 held for 3 cycles, done in cycle 4.
REQ-034 SHALL be covered by a bench case: LSR1 with count=0 -> no step_valid, cpipe1s stays 8'h00, done in cycle 1.
REQ-035 SHALL be covered by a bench case: ZLO with count=31 and rst pulsed in cycle 10 -> cpipe1s=8'h00, no done pulse, req_ready=1 after rst falls.
REQ-036 SHALL be covered by a bench case: req_valid held high during ISSUE with a different op -> the ongoing word is unchanged and the second request is accepted only after DONE.
REQ-037 SHALL be covered by a bench case: all four ops with count=1 -> the words A0, A2, E0 and E2 (hex), each for exactly one cycle.
